// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit between the MIPS execute stage and the data memory.
// Takes one load/store at a time, checks size, alignment and address range, then
// drives one memory access with big-endian lane-aligned data and byte enables.
// Load data is extracted and extended. The response is returned over valid/ready.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_*               request handshake: store flag, size code, byte address, store data
//   resp_*              response handshake: extended load data, error flag
//   mem_*               memory port: word address, store data, read/write, strobe,
//                       byte-lane enables, read data
module mips_lsu #(
    parameter int unsigned                  DATA_WIDTH   = 32,
    parameter int unsigned                  ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]        BASE_ADDRESS = 32'h8002_0000,
    parameter int unsigned                  MEM_BYTES    = 1048576,
    parameter int unsigned                  READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read_write,
    output logic                  mem_enable,
    output logic [3:0]            mem_byte_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int unsigned          AW1       = ADDR_WIDTH + 1;
    localparam int unsigned          CNT_W     = 2;
    localparam logic [CNT_W-1:0]     CNT_INIT  = CNT_W'(READ_LATENCY - 1);
    // Range bounds carried in one extra bit so BASE + MEM_BYTES cannot wrap
    localparam logic [AW1-1:0]       BASE_EXT  = {1'b0, BASE_ADDRESS};
    localparam logic [AW1-1:0]       LIMIT_EXT = BASE_EXT + AW1'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             store_q;
    logic [2:0]       size_q;
    logic [1:0]       off_q;

    logic                  size_ok;
    logic                  misaligned;
    logic                  in_range;
    logic                  req_err;
    logic [3:0]            we_c;
    logic [DATA_WIDTH-1:0] din_c;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_c;

    // Request decode: size legality, alignment, store lane enables and replicated data
    always_comb begin
        size_ok    = 1'b0;
        misaligned = 1'b0;
        we_c       = 4'b1111;
        din_c      = req_wdata;
        case (req_size)
            3'b000, 3'b100: begin
                size_ok = 1'b1;
                we_c    = 4'b1000 >> req_addr[1:0];
                din_c   = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                size_ok    = 1'b1;
                misaligned = req_addr[0];
                we_c       = 4'b1100 >> req_addr[1:0];
                din_c      = {2{req_wdata[15:0]}};
            end
            3'b011: begin
                size_ok    = 1'b1;
                misaligned = |req_addr[1:0];
            end
            default: ;
        endcase
    end

    assign in_range = ({1'b0, req_addr} >= BASE_EXT) && ({1'b0, req_addr} < LIMIT_EXT);
    assign req_err  = !size_ok || misaligned || !in_range;

    // Load extraction, big-endian: offset 0 is bits 31:24
    always_comb begin
        lane_byte = 8'h00;
        case (off_q)
            2'd0: lane_byte = mem_data_out[31:24];
            2'd1: lane_byte = mem_data_out[23:16];
            2'd2: lane_byte = mem_data_out[15:8];
            2'd3: lane_byte = mem_data_out[7:0];
            default: ;
        endcase
        lane_half = off_q[1] ? mem_data_out[15:0] : mem_data_out[31:16];
        case (size_q)
            3'b000:  load_c = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_c = {24'h000000, lane_byte};
            3'b001:  load_c = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_c = {16'h0000, lane_half};
            default: load_c = mem_data_out;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            store_q        <= 1'b0;
            size_q         <= 3'b000;
            off_q          <= 2'b00;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_enable     <= 1'b0;
            mem_read_write <= 1'b1;
            mem_byte_we    <= 4'b0000;
            mem_address    <= '0;
            mem_data_in    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        store_q   <= req_store;
                        size_q    <= req_size;
                        off_q     <= req_addr[1:0];
                        if (req_err) begin
                            // No memory access on the error path
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_q        <= ISSUE;
                            mem_enable     <= 1'b1;
                            mem_read_write <= !req_store;
                            mem_address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_byte_we    <= req_store ? we_c : 4'b0000;
                            if (req_store) begin
                                mem_data_in <= din_c;
                            end
                        end
                    end
                end
                ISSUE: begin
                    mem_enable     <= 1'b0;
                    mem_byte_we    <= 4'b0000;
                    mem_read_write <= 1'b1;
                    if (store_q) begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_c;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q    <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: two instances (read latency 1 and 3) share one request stream.
// Each has its own memory model; results are compared against a byte-level
// big-endian reference memory.
module tb_mips_lsu;

    localparam logic [31:0] BASE   = 32'h8002_0000;
    localparam int unsigned MEMB   = 1048576;
    localparam int unsigned NWORDS = MEMB / 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_error;
    logic [1:0]       mem_enable;
    logic [1:0]       mem_read_write;
    logic [1:0][31:0] resp_rdata;
    logic [1:0][31:0] mem_address;
    logic [1:0][31:0] mem_data_in;
    logic [1:0][31:0] mem_data_out;
    logic [1:0][3:0]  mem_byte_we;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_bytes [int unsigned];

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input logic [31:0] widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            localparam int unsigned RL = (g == 0) ? 1 : 3;
            logic [31:0] words [NWORDS];
            logic [31:0] p0, p1, p2;
            logic [31:0] widx;
            logic [31:0] mask;
            int          en_cnt = 0;

            mips_lsu #(.READ_LATENCY(RL)) u_dut (
                .clock          (clock),
                .reset          (reset),
                .req_valid      (req_valid),
                .req_ready      (req_ready[g]),
                .req_store      (req_store),
                .req_size       (req_size),
                .req_addr       (req_addr),
                .req_wdata      (req_wdata),
                .resp_valid     (resp_valid[g]),
                .resp_ready     (resp_ready),
                .resp_rdata     (resp_rdata[g]),
                .resp_error     (resp_error[g]),
                .mem_address    (mem_address[g]),
                .mem_data_in    (mem_data_in[g]),
                .mem_read_write (mem_read_write[g]),
                .mem_enable     (mem_enable[g]),
                .mem_byte_we    (mem_byte_we[g]),
                .mem_data_out   (mem_data_out[g])
            );

            initial begin
                for (int i = 0; i < int'(NWORDS); i++) words[i] = init_word(32'(i));
            end

            assign widx = (mem_address[g] - BASE) >> 2;
            assign mask = {{8{mem_byte_we[g][3]}}, {8{mem_byte_we[g][2]}},
                           {8{mem_byte_we[g][1]}}, {8{mem_byte_we[g][0]}}};

            // Synchronous memory: read data valid RL edges after the enable edge
            always @(posedge clock) begin
                if (mem_enable[g]) begin
                    en_cnt <= en_cnt + 1;
                    if (mem_read_write[g]) p0 <= words[widx[17:0]];
                    else words[widx[17:0]] <= (words[widx[17:0]] & ~mask) | (mem_data_in[g] & mask);
                end
                p1 <= p0;
                p2 <= p1;
            end

            assign mem_data_out[g] = (RL == 1) ? p0 : (RL == 2) ? p1 : p2;
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd3:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] sz, input logic [31:0] a);
        longint unsigned la  = 64'(a);
        longint unsigned lim = 64'(BASE) + 64'(MEMB);
        int n = nbytes(sz);
        if (n == 0) return 1'b1;
        if (la % longint'(n) != 0) return 1'b1;
        if (la < 64'(BASE) || la >= lim) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_bytes.exists(a)) return ref_bytes[a];
        w = init_word((a - BASE) >> 2);
        return w[8*(3 - int'(a[1:0])) +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_byte(a + 32'(i)));
        if (sz == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (sz == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_bytes[a + 32'(i)] = wd[8*(n - 1 - i) +: 8];
    endtask

    // ---------------- transaction driver ----------------
    task automatic do_req(input logic st, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_din;
        logic [3:0]  exp_we;
        int          exp_lat [2];
        int          lat [2];
        int          en0 [2];
        int          cyc;
        int          n;
        n       = nbytes(sz);
        exp_err = ref_err(sz, a);
        exp_rd  = 32'h0;
        exp_we  = 4'b0000;
        exp_din = wd;
        if (!exp_err && !st) exp_rd = ref_load(sz, a);
        if (!exp_err && st) begin
            for (int i = 0; i < n; i++) exp_we[3 - int'((a + 32'(i)) % 4)] = 1'b1;
            if (n == 1) exp_din = {4{wd[7:0]}};
            if (n == 2) exp_din = {2{wd[15:0]}};
        end
        exp_lat[0] = exp_err ? 1 : (st ? 2 : 3);
        exp_lat[1] = exp_err ? 1 : (st ? 2 : 5);
        en0[0] = g_dut[0].en_cnt;
        en0[1] = g_dut[1].en_cnt;
        for (int k = 0; k < 2; k++) check($sformatf("ready_before%0d", k), 32'(req_ready[k]), 32'd1);

        req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        lat = '{0, 0};
        cyc = 1;
        while ((lat[0] == 0 || lat[1] == 0) && cyc < 20) begin
            if (cyc == 1 && !exp_err) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("issue_en%0d", k), 32'(mem_enable[k]), 32'd1);
                    check($sformatf("issue_rw%0d", k), 32'(mem_read_write[k]), 32'(!st));
                    check($sformatf("issue_addr%0d", k), mem_address[k], {a[31:2], 2'b00});
                    check($sformatf("issue_we%0d", k), 32'(mem_byte_we[k]), 32'(exp_we));
                    if (st) check($sformatf("issue_din%0d", k), mem_data_in[k], exp_din);
                end
            end
            for (int k = 0; k < 2; k++) if (lat[k] == 0 && resp_valid[k]) lat[k] = cyc;
            if (lat[0] == 0 || lat[1] == 0) begin
                @(negedge clock);
                cyc++;
            end
        end

        // Stall the response while a second request is presented
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_store = 1'b0; req_size = 3'd3; req_addr = BASE;
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("stall_valid%0d", k), 32'(resp_valid[k]), 32'd1);
                check($sformatf("stall_rdata%0d", k), resp_rdata[k], exp_rd);
                check($sformatf("stall_ready%0d", k), 32'(req_ready[k]), 32'd0);
            end
        end
        req_valid = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check($sformatf("lat%0d", k), 32'(lat[k]), 32'(exp_lat[k]));
            check($sformatf("err%0d", k), 32'(resp_error[k]), 32'(exp_err));
            check($sformatf("rdata%0d", k), resp_rdata[k], exp_rd);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("done_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("done_ready%0d", k), 32'(req_ready[k]), 32'd1);
        end
        check("en_count0", 32'(g_dut[0].en_cnt - en0[0]), exp_err ? 32'd0 : 32'd1);
        check("en_count1", 32'(g_dut[1].en_cnt - en0[1]), exp_err ? 32'd0 : 32'd1);
        if (st && !exp_err) ref_store(sz, a, wd);
    endtask

    task automatic reset_check(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ready%0d", tag, k), 32'(req_ready[k]), 32'd1);
            check($sformatf("%s_rvalid%0d", tag, k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("%s_rdata%0d", tag, k), resp_rdata[k], 32'd0);
            check($sformatf("%s_rerr%0d", tag, k), 32'(resp_error[k]), 32'd0);
            check($sformatf("%s_en%0d", tag, k), 32'(mem_enable[k]), 32'd0);
            check($sformatf("%s_rw%0d", tag, k), 32'(mem_read_write[k]), 32'd1);
            check($sformatf("%s_we%0d", tag, k), 32'(mem_byte_we[k]), 32'd0);
            check($sformatf("%s_addr%0d", tag, k), mem_address[k], 32'd0);
            check($sformatf("%s_din%0d", tag, k), mem_data_in[k], 32'd0);
        end
    endtask

    task automatic no_resp_check(input string tag);
        logic seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (resp_valid != 2'b00) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic random_req();
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;
        r = int'($urandom_range(0, 9));
        case (r)
            0, 1:    sz = 3'd0;
            2, 3:    sz = 3'd1;
            4, 5:    sz = 3'd3;
            6:       sz = 3'd4;
            7:       sz = 3'd5;
            default: sz = 3'($urandom_range(0, 7));
        endcase
        r = int'($urandom_range(0, 19));
        case (r)
            16:      a = BASE - 32'($urandom_range(1, 4));
            17:      a = BASE + 32'(MEMB) - 32'($urandom_range(1, 4));
            18:      a = BASE + 32'(MEMB) + 32'($urandom_range(0, 7));
            19:      a = $urandom;
            default: a = BASE + 32'($urandom_range(0, 63));
        endcase
        do_req(1'($urandom_range(0, 1)), sz, a, $urandom, int'($urandom_range(0, 2)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_check("rst");
        reset = 1'b0;
        @(negedge clock);

        do_req(1'b1, 3'd3, 32'h8002_0000, 32'h1122_3344, 0);
        do_req(1'b1, 3'd0, 32'h8002_0001, 32'h0000_00AB, 0);
        do_req(1'b0, 3'd0, 32'h8002_0001, 32'h0, 0);
        do_req(1'b0, 3'd4, 32'h8002_0001, 32'h0, 0);
        do_req(1'b1, 3'd1, 32'h8002_0006, 32'h0000_8001, 0);
        do_req(1'b0, 3'd1, 32'h8002_0006, 32'h0, 0);
        do_req(1'b0, 3'd5, 32'h8002_0006, 32'h0, 0);
        do_req(1'b0, 3'd3, 32'h8002_0002, 32'h0, 0);
        do_req(1'b0, 3'd1, 32'h8002_0003, 32'h0, 0);
        do_req(1'b1, 3'd3, 32'h8001_FFFC, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'd3, 32'h8012_0000, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h8002_0000, 32'h0, 0);
        do_req(1'b0, 3'd3, 32'h8002_0000, 32'h0, 5);
        do_req(1'b0, 3'd3, 32'h800F_FFFC + 32'h0002_0000, 32'h0, 0);

        for (int t = 0; t < 150; t++) random_req();

        // Reset while a load is waiting for memory data
        req_valid = 1'b1; req_store = 1'b0; req_size = 3'd3; req_addr = BASE + 32'd8;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        reset_check("abort_lw");
        @(negedge clock);
        reset = 1'b0;
        no_resp_check("abort_lw_noresp");

        // Reset while a store is issuing; memory must stay unchanged
        req_valid = 1'b1; req_store = 1'b1; req_size = 3'd3; req_addr = BASE + 32'd12;
        req_wdata = 32'hCAFE_F00D;
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        reset_check("abort_sw");
        @(negedge clock);
        reset = 1'b0;
        no_resp_check("abort_sw_noresp");
        do_req(1'b0, 3'd3, BASE + 32'd12, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
